// File: rtl/qlal4s3b_pkg.sv
// Shared types and constants for the EOS S3 fabric clock/reset stand-in.
// Divider values are stored as div_t; a zero divider always means "half-period of 1".
package qlal4s3b_pkg;

  localparam int DIV_W        = 8;
  localparam int RST_HOLD_DEF = 4;

  typedef logic [DIV_W-1:0] div_t;

  // Hold counter width; never narrower than one bit.
  function automatic int hold_w(input int hold);
    return (hold < 1) ? 1 : $clog2(hold + 1);
  endfunction

  localparam int HOLD_W = hold_w(RST_HOLD_DEF);

  function automatic div_t div_fix(input div_t d);
    return (d == '0) ? div_t'(1) : d;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One derived-clock channel: half-period counter, pending/active divider,
// glitch-free enable freeze and the post-reset hold for the domain reset.
module clk_div_chan
  import qlal4s3b_pkg::*;
#(
  parameter div_t DIV_INIT = 8'd1,
  parameter int   RST_HOLD = RST_HOLD_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_in,
  input  logic             en,
  output logic             sys_clk,
  output logic             sys_rst
);

  localparam int            HW       = hold_w(RST_HOLD);
  localparam logic [HW-1:0] HOLD_MAX = HW'(RST_HOLD);
  localparam div_t          INIT     = div_fix(DIV_INIT);

  div_t          cnt;
  div_t          active;
  div_t          pending;
  logic [HW-1:0] hold;
  logic [HW-1:0] hold_nxt;
  logic          adv;
  logic          tick;
  logic          rise;

  // A high phase always runs to completion, so the divider keeps advancing
  // while the output is high even after the enable drops.
  always_comb begin
    adv      = en | sys_clk;
    tick     = (cnt == active - div_t'(1));
    rise     = adv & tick & ~sys_clk;
    hold_nxt = hold;
    if (rise && (hold != HOLD_MAX)) hold_nxt = hold + HW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      active  <= INIT;
      pending <= INIT;
      hold    <= '0;
      sys_clk <= 1'b0;
      sys_rst <= 1'b1;
    end else begin
      if (div_load) pending <= div_fix(div_in);
      if (adv) begin
        if (tick) begin
          cnt     <= '0;
          sys_clk <= ~sys_clk;
          // New widths only take effect at a falling toggle: no runt pulses.
          if (sys_clk) active <= pending;
        end else begin
          cnt <= cnt + div_t'(1);
        end
      end else begin
        cnt    <= '0;
        active <= pending;
      end
      hold <= hold_nxt;
      if (hold_nxt == HOLD_MAX) sys_rst <= 1'b0;
    end
  end

endmodule

// File: rtl/qlal4s3b_clk_rst_gen.sv
// Fabric clock/reset service: two independent divided clocks with per-domain
// resets, a shared divider-load strobe and a combined lock indication.
module qlal4s3b_clk_rst_gen
  import qlal4s3b_pkg::*;
#(
  parameter div_t DIV0_INIT = 8'd1,
  parameter div_t DIV1_INIT = 8'd4,
  parameter int   RST_HOLD  = RST_HOLD_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             div_load,
  input  logic [DIV_W-1:0] clk0_div,
  input  logic [DIV_W-1:0] clk1_div,
  input  logic             clk0_en,
  input  logic             clk1_en,
  output logic             Sys_Clk0,
  output logic             Sys_Clk0_Rst,
  output logic             Sys_Clk1,
  output logic             Sys_Clk1_Rst,
  output logic             locked
);

  clk_div_chan #(
    .DIV_INIT (DIV0_INIT),
    .RST_HOLD (RST_HOLD)
  ) u_chan0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .div_load (div_load),
    .div_in   (clk0_div),
    .en       (clk0_en),
    .sys_clk  (Sys_Clk0),
    .sys_rst  (Sys_Clk0_Rst)
  );

  clk_div_chan #(
    .DIV_INIT (DIV1_INIT),
    .RST_HOLD (RST_HOLD)
  ) u_chan1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .div_load (div_load),
    .div_in   (clk1_div),
    .en       (clk1_en),
    .sys_clk  (Sys_Clk1),
    .sys_rst  (Sys_Clk1_Rst)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) locked <= 1'b0;
    else        locked <= ~Sys_Clk0_Rst & ~Sys_Clk1_Rst;
  end

endmodule

// File: tb/tb_qlal4s3b_clk_rst_gen.sv
// Self-checking bench for qlal4s3b_clk_rst_gen: a per-cycle reference model feeds
// an expected-output queue, plus directed timing checks on the derived clocks.
module tb_qlal4s3b_clk_rst_gen;

  localparam logic [7:0] DIV0_TB     = 8'd1;
  localparam logic [7:0] DIV1_TB     = 8'd4;
  localparam int         RST_HOLD_TB = 4;

  // clock / reset block
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       div_load = 1'b0;
  logic [7:0] clk0_div = 8'd0;
  logic [7:0] clk1_div = 8'd0;
  logic       clk0_en = 1'b1;
  logic       clk1_en = 1'b1;
  logic       Sys_Clk0, Sys_Clk0_Rst, Sys_Clk1, Sys_Clk1_Rst, locked;

  always #5 clk = ~clk;

  qlal4s3b_clk_rst_gen #(
    .DIV0_INIT (DIV0_TB),
    .DIV1_INIT (DIV1_TB),
    .RST_HOLD  (RST_HOLD_TB)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .div_load     (div_load),
    .clk0_div     (clk0_div),
    .clk1_div     (clk1_div),
    .clk0_en      (clk0_en),
    .clk1_en      (clk1_en),
    .Sys_Clk0     (Sys_Clk0),
    .Sys_Clk0_Rst (Sys_Clk0_Rst),
    .Sys_Clk1     (Sys_Clk1),
    .Sys_Clk1_Rst (Sys_Clk1_Rst),
    .locked       (locked)
  );

  // scoreboard
  logic [4:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, $signed(got), $signed(want));
    end
  endtask

  // reference model, one call per clk edge, using the inputs about to be sampled
  logic m_clk[2];
  logic m_rst[2];
  logic m_lock;
  int   m_hold[2];
  int   m_act[2];
  int   m_pend[2];
  int   m_left[2];

  task automatic model_reset();
    for (int ch = 0; ch < 2; ch++) begin
      m_clk[ch]  = 1'b0;
      m_rst[ch]  = 1'b1;
      m_hold[ch] = 0;
      m_act[ch]  = (ch == 0) ? int'(DIV0_TB) : int'(DIV1_TB);
      m_pend[ch] = m_act[ch];
      m_left[ch] = m_act[ch];
    end
    m_lock = 1'b0;
  endtask

  task automatic model_step();
    logic nl;
    int   dv[2];
    logic en[2];
    dv[0] = int'(clk0_div);
    dv[1] = int'(clk1_div);
    en[0] = clk0_en;
    en[1] = clk1_en;
    if (!rst_n) begin
      model_reset();
      return;
    end
    nl = ~m_rst[0] & ~m_rst[1];
    for (int ch = 0; ch < 2; ch++) begin
      if (en[ch] || m_clk[ch]) begin
        if (m_left[ch] == 1) begin
          if (m_clk[ch]) begin
            m_clk[ch] = 1'b0;
            m_act[ch] = m_pend[ch];
          end else begin
            m_clk[ch] = 1'b1;
            if (m_hold[ch] < RST_HOLD_TB) m_hold[ch]++;
            if (m_hold[ch] == RST_HOLD_TB) m_rst[ch] = 1'b0;
          end
          m_left[ch] = m_act[ch];
        end else begin
          m_left[ch]--;
        end
      end else begin
        m_act[ch]  = m_pend[ch];
        m_left[ch] = m_pend[ch];
      end
      if (div_load) m_pend[ch] = (dv[ch] == 0) ? 1 : dv[ch];
    end
    m_lock = nl;
  endtask

  // driver: one clk cycle, compare DUT outputs against the queued expectation
  task automatic cycle();
    logic [4:0] want, got;
    model_step();
    exp_q.push_back({m_clk[0], m_rst[0], m_clk[1], m_rst[1], m_lock});
    @(posedge clk);
    #1;
    got  = {Sys_Clk0, Sys_Clk0_Rst, Sys_Clk1, Sys_Clk1_Rst, locked};
    want = exp_q.pop_front();
    check("sb_outputs", got, want);
  endtask

  function automatic logic sysclk(input int ch);
    return (ch == 0) ? Sys_Clk0 : Sys_Clk1;
  endfunction

  task automatic wait_level(input int ch, input logic lvl, output bit ok);
    int n = 0;
    while (sysclk(ch) !== lvl && n < 64) begin
      cycle();
      n++;
    end
    ok = (sysclk(ch) === lvl);
  endtask

  // width in clk cycles of the next complete phase at level lvl; -1 on timeout
  task automatic phase_width(input int ch, input logic lvl, output int w);
    int n = 0;
    w = 0;
    while (sysclk(ch) === lvl && n < 64) begin cycle(); n++; end
    while (sysclk(ch) !== lvl && n < 64) begin cycle(); n++; end
    while (sysclk(ch) === lvl && n < 64) begin cycle(); n++; w++; end
    if (n >= 64) w = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  t_r0, t_r1, t_lk, rise_a, rise_b, w, n, bad;
    logic prev1;
    bit  ok;

    // reset state
    rst_n = 1'b0;
    repeat (3) cycle();
    check("rst_clk0", Sys_Clk0, 0);
    check("rst_rst0", Sys_Clk0_Rst, 1);
    check("rst_clk1", Sys_Clk1, 0);
    check("rst_rst1", Sys_Clk1_Rst, 1);
    check("rst_locked", locked, 0);

    // defaults: clk/2 and clk/8, reset release after 4 rises, locked one later
    rst_n = 1'b1;
    t_r0 = -1; t_r1 = -1; t_lk = -1; rise_a = -1; rise_b = -1; prev1 = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      cycle();
      if (t_r0 < 0 && Sys_Clk0_Rst === 1'b0) t_r0 = i;
      if (t_r1 < 0 && Sys_Clk1_Rst === 1'b0) t_r1 = i;
      if (t_lk < 0 && locked === 1'b1) t_lk = i;
      if (Sys_Clk1 === 1'b1 && prev1 === 1'b0) begin
        if (rise_a < 0) rise_a = i;
        else if (rise_b < 0) rise_b = i;
      end
      prev1 = Sys_Clk1;
    end
    check("rst0_fall_cycle", t_r0, 7);
    check("rst1_fall_cycle", t_r1, 28);
    check("locked_rise_cycle", t_lk, 29);
    check("clk1_first_rise", rise_a, 4);
    check("clk1_period", rise_b - rise_a, 8);
    phase_width(0, 1'b1, w); check("clk0_high_default", w, 1);
    phase_width(0, 1'b0, w); check("clk0_low_default", w, 1);

    // divider load while Sys_Clk0 is high; clk1_div=0 behaves as 1
    wait_level(0, 1'b1, ok); check("wait_clk0_high", ok, 1);
    clk0_div = 8'd3;
    clk1_div = 8'd0;
    div_load = 1'b1;
    cycle();
    div_load = 1'b0;
    check("load_old_high_done", Sys_Clk0, 0);
    repeat (20) cycle();
    phase_width(0, 1'b1, w); check("clk0_high_div3", w, 3);
    phase_width(0, 1'b0, w); check("clk0_low_div3", w, 3);
    phase_width(1, 1'b1, w); check("clk1_high_div0", w, 1);
    phase_width(1, 1'b0, w); check("clk1_low_div0", w, 1);

    // enable stop mid-high and restart
    wait_level(0, 1'b0, ok); check("wait_clk0_low", ok, 1);
    wait_level(0, 1'b1, ok); check("wait_clk0_rise", ok, 1);
    clk0_en = 1'b0;
    n = 1;
    while (Sys_Clk0 === 1'b1 && n < 64) begin
      cycle();
      if (Sys_Clk0 === 1'b1) n++;
    end
    check("stop_high_width", n, 3);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (Sys_Clk0 !== 1'b0) bad++;
    end
    check("stop_held_low", bad, 0);
    clk0_en = 1'b1;
    n = 0;
    while (Sys_Clk0 !== 1'b1 && n < 64) begin cycle(); n++; end
    check("restart_first_rise", n, 3);

    // mid-operation reset restores INIT dividers
    rst_n = 1'b0;
    cycle();
    check("mid_rst_clk0", Sys_Clk0, 0);
    check("mid_rst_rst0", Sys_Clk0_Rst, 1);
    check("mid_rst_clk1", Sys_Clk1, 0);
    check("mid_rst_rst1", Sys_Clk1_Rst, 1);
    check("mid_rst_locked", locked, 0);
    rst_n = 1'b1;
    phase_width(0, 1'b1, w); check("clk0_high_reinit", w, 1);
    phase_width(1, 1'b1, w); check("clk1_high_reinit", w, 4);

    // clock 1 disabled from reset
    clk1_en = 1'b0;
    rst_n   = 1'b0;
    cycle();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (Sys_Clk1 !== 1'b0 || Sys_Clk1_Rst !== 1'b1 || locked !== 1'b0) bad++;
    end
    check("clk1_off_stuck", bad, 0);
    check("clk0_rst_released", Sys_Clk0_Rst, 0);

    // random enables, loads and occasional resets against the model
    clk1_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) clk0_en = ~clk0_en;
      if ($urandom_range(0, 15) == 0) clk1_en = ~clk1_en;
      div_load = ($urandom_range(0, 7) == 0);
      clk0_div = 8'($urandom_range(0, 5));
      clk1_div = 8'($urandom_range(0, 5));
      rst_n    = ($urandom_range(0, 149) != 0);
      cycle();
    end
    div_load = 1'b0;
    rst_n    = 1'b1;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
